// File: rtl/sclk_gen_multi.sv
// sclk_gen_multi: N_CH independent divided serial clocks with glitch-free ratio change, clean stop and phase-align restart
module sclk_gen_multi #(
  parameter int N_CH = 2,
  parameter int DIV_W = 8,
  parameter logic [N_CH-1:0] CPOL_MASK = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [N_CH-1:0]       en_i,
  input  logic [N_CH*DIV_W-1:0] div_i,
  input  logic                  sync_i,
  output logic [N_CH-1:0]       sclk_o,
  output logic [N_CH-1:0]       rise_o,
  output logic [N_CH-1:0]       fall_o,
  output logic [N_CH-1:0]       busy_o
);
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic idle = CPOL_MASK[c];
    state_t state;
    logic [DIV_W-1:0] cnt, div_q, div;
    logic sclk, rise, fall, busy;
    assign div = div_i[c*DIV_W +: DIV_W];
    assign sclk_o[c] = sclk;
    assign rise_o[c] = rise;
    assign fall_o[c] = fall;
    assign busy_o[c] = busy;
    // Per-channel FSM: sync restart wins, then enable/disable handling, then half-period count and toggle
    always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
        state <= IDLE;
        cnt   <= '0;
        div_q <= '0;
        sclk  <= idle;
        rise  <= 1'b0;
        fall  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        if (sync_i && en_i[c]) begin
          state <= RUN;
          cnt   <= '0;
          div_q <= div;
          sclk  <= idle;
          rise  <= (sclk != idle) && idle;
          fall  <= (sclk != idle) && !idle;
          busy  <= 1'b1;
        end else if (state == IDLE) begin
          if (en_i[c]) begin
            state <= RUN;
            cnt   <= '0;
            div_q <= div;
            busy  <= 1'b1;
          end
        end else if (!en_i[c] && sclk == idle) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end else if (cnt == div_q) begin
          sclk  <= ~sclk;
          rise  <= ~sclk;
          fall  <= sclk;
          cnt   <= '0;
          div_q <= div;
          state <= en_i[c] ? RUN : IDLE;
          busy  <= en_i[c];
        end else begin
          cnt   <= cnt + 1'b1;
          state <= en_i[c] ? RUN : STOP;
        end
      end
  end
endmodule

// File: tb/tb_sclk_gen_multi.sv
// tb_sclk_gen_multi: scoreboard bench for sclk_gen_multi with expected per-cycle events derived from the divide arithmetic
module tb_sclk_gen_multi;
  localparam logic [1:0] CPOL = 2'b10;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] en;
  logic [7:0] div0, div1;
  logic sync;
  logic [1:0] sclk_o, rise_o, fall_o, busy_o;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e, s;

  typedef struct {
    string tag;
    int at;
    int ch;
    int kind;
    bit val;
  } exp_t;
  exp_t sb[$];
  string kn[4] = '{"sclk", "rise", "fall", "busy"};

  sclk_gen_multi #(.N_CH(2), .DIV_W(8), .CPOL_MASK(CPOL)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .div_i({div1, div0}), .sync_i(sync),
    .sclk_o(sclk_o), .rise_o(rise_o), .fall_o(fall_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic want(string tag, int at, int ch, int kind, bit val);
    sb.push_back('{tag, at, ch, kind, val});
  endtask

  task automatic want_all(string tag, int at, int ch, bit sv, bit rv, bit fv, bit bv);
    want(tag, at, ch, 0, sv);
    want(tag, at, ch, 1, rv);
    want(tag, at, ch, 2, fv);
    want(tag, at, ch, 3, bv);
  endtask

  // running clock from edge e with half-period d+1, covering offsets k0..k1
  task automatic expect_clk(string tag, int ch, int at0, int d, int k0, int k1);
    for (int k = k0; k <= k1; k++) begin
      int h;
      bit lvl, edg;
      h = k / (d + 1);
      lvl = CPOL[ch] ^ h[0];
      edg = (k > 0) && (k % (d + 1) == 0);
      want_all(tag, at0 + k, ch, lvl, edg && lvl, edg && !lvl, 1'b1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].at == cyc) begin
        logic [1:0] v;
        v = sb[i].kind == 0 ? sclk_o : sb[i].kind == 1 ? rise_o : sb[i].kind == 2 ? fall_o : busy_o;
        check($sformatf("%s@%0d.%s%0d", sb[i].tag, cyc, kn[sb[i].kind], sb[i].ch), {31'd0, v[sb[i].ch]}, {31'd0, sb[i].val});
        sb.delete(i);
      end
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n = 1'b1;
    en = 2'b00;
    div0 = '0;
    div1 = '0;
    sync = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_sclk", {30'd0, sclk_o}, {30'd0, CPOL});
    check("rst_busy", {30'd0, busy_o}, 32'd0);
    check("rst_rise", {30'd0, rise_o}, 32'd0);
    check("rst_fall", {30'd0, fall_o}, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    // div=0 gives clk/2, then disable from the high level
    div0 = 8'd0;
    e = cyc + 1;
    en = 2'b01;
    expect_clk("d0", 0, e, 0, 0, 7);
    want_all("d0_ch1", e + 3, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    want_all("d0_off", e + 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    want_all("d0_idle", e + 9, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(8);
    en = 2'b00;
    ticks(2);
    // ratio change in mid high phase takes effect next half-period
    div0 = 8'd3;
    e = cyc + 1;
    en = 2'b01;
    expect_clk("dchg", 0, e, 3, 0, 7);
    want_all("dchg", e + 8, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    want_all("dchg", e + 9, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    want_all("dchg", e + 10, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    want_all("dchg", e + 11, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    want_all("dchg", e + 12, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    want_all("dchg_off", e + 13, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(6);
    div0 = 8'd1;
    ticks(7);
    en = 2'b00;
    ticks(2);
    // disable one cycle into high: full high phase, single fall, no further rise
    div0 = 8'd3;
    e = cyc + 1;
    en = 2'b01;
    expect_clk("stop", 0, e, 3, 0, 7);
    want_all("stop_end", e + 8, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 9; k <= 14; k++) want_all("stop_idle", e + k, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(5);
    en = 2'b00;
    ticks(10);
    // re-enable while stopping keeps the clock continuous
    e = cyc + 1;
    en = 2'b01;
    expect_clk("resume", 0, e, 3, 0, 15);
    want_all("resume_off", e + 16, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(5);
    en = 2'b00;
    tick();
    en = 2'b01;
    ticks(10);
    en = 2'b00;
    tick();
    // sync restarts both running channels at their idle level
    div0 = 8'd2;
    div1 = 8'd5;
    e = cyc + 1;
    en = 2'b11;
    expect_clk("pre", 0, e, 2, 0, 3);
    expect_clk("pre", 1, e, 5, 0, 3);
    ticks(4);
    sync = 1'b1;
    s = cyc + 1;
    want_all("sync", s, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    want_all("sync", s, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_clk("post", 0, s, 2, 1, 20);
    expect_clk("post", 1, s, 5, 1, 20);
    tick();
    sync = 1'b0;
    ticks(20);
    en = 2'b00;
    want_all("off0", s + 21, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 21; k <= 23; k++) want_all("off1_stop", s + k, 1, 1'b0, 1'b0, 1'b0, 1'b1);
    want_all("off1_end", s + 24, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    ticks(4);
    // sync leaves a disabled channel alone
    div0 = 8'd2;
    e = cyc + 1;
    en = 2'b01;
    expect_clk("pre2", 0, e, 2, 0, 1);
    ticks(2);
    sync = 1'b1;
    s = cyc + 1;
    want_all("sync_dis", s, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_clk("post2", 0, s, 2, 0, 7);
    want_all("post2_off", s + 8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    sync = 1'b0;
    ticks(7);
    en = 2'b00;
    tick();
    // channel 1 idles high, first edge is a fall
    div1 = 8'd1;
    e = cyc + 1;
    en = 2'b10;
    expect_clk("cpol", 1, e, 1, 0, 5);
    want_all("cpol_off", e + 6, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(6);
    en = 2'b00;
    tick();
    // async reset in mid high phase, then a fresh idle half-period
    div0 = 8'd3;
    e = cyc + 1;
    en = 2'b01;
    expect_clk("prerst", 0, e, 3, 0, 5);
    ticks(6);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sclk", {30'd0, sclk_o}, {30'd0, CPOL});
    check("arst_busy", {30'd0, busy_o}, 32'd0);
    check("arst_rise", {30'd0, rise_o}, 32'd0);
    check("arst_fall", {30'd0, fall_o}, 32'd0);
    #1 rst_n = 1'b1;
    e = cyc + 1;
    expect_clk("postrst", 0, e, 3, 0, 9);
    want_all("postrst_off", e + 10, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(10);
    en = 2'b00;
    tick();
    check("sb_drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
